// File: rtl/wb_command_master.sv
// Wishbone classic single-access initiator. Accepts one command on a
// valid/ready stream, runs exactly one bus cycle with a bounded wait for ack,
// and returns one response (read data plus timeout flag) per command.
module wb_command_master #(
   parameter int unsigned WB_ADR_WIDTH   = 37,
   parameter int unsigned WB_DAT_WIDTH   = 64,
   parameter int unsigned WB_SEL_WIDTH   = WB_DAT_WIDTH / 8,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned ERRCNT_WIDTH   = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   // Command stream
   input  logic [WB_ADR_WIDTH-1:0] s_cmd_adr,
   input  logic [WB_DAT_WIDTH-1:0] s_cmd_dat,
   input  logic [WB_SEL_WIDTH-1:0] s_cmd_sel,
   input  logic                    s_cmd_we,
   input  logic                    s_cmd_valid,
   output logic                    s_cmd_ready,
   // Response stream
   output logic [WB_DAT_WIDTH-1:0] m_rsp_dat,
   output logic                    m_rsp_we,
   output logic                    m_rsp_timeout,
   output logic                    m_rsp_valid,
   input  logic                    m_rsp_ready,
   // Wishbone master port
   output logic [WB_ADR_WIDTH-1:0] m_wb_adr_o,
   output logic [WB_DAT_WIDTH-1:0] m_wb_dat_o,
   input  logic [WB_DAT_WIDTH-1:0] m_wb_dat_i,
   output logic [WB_SEL_WIDTH-1:0] m_wb_sel_o,
   output logic                    m_wb_we_o,
   output logic                    m_wb_stb_o,
   input  logic                    m_wb_ack_i,
   // Status
   output logic                    busy,
   output logic [ERRCNT_WIDTH-1:0] timeout_count
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StBus,
      StResp
   } state_e;

   state_e                  state_q;
   logic [WB_ADR_WIDTH-1:0] adr_q;
   logic [WB_DAT_WIDTH-1:0] dat_q;
   logic [WB_SEL_WIDTH-1:0] sel_q;
   logic                    we_q;
   logic                    stb_q;
   logic [CntW-1:0]         wait_cnt_q;
   logic [WB_DAT_WIDTH-1:0] rsp_dat_q;
   logic                    rsp_we_q;
   logic                    rsp_timeout_q;
   logic                    rsp_valid_q;
   logic [ERRCNT_WIDTH-1:0] timeout_count_q;

   // Access sequencer: every bus and response output is a register of this FSM.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q         <= StIdle;
         adr_q           <= '0;
         dat_q           <= '0;
         sel_q           <= '0;
         we_q            <= 1'b0;
         stb_q           <= 1'b0;
         wait_cnt_q      <= '0;
         rsp_dat_q       <= '0;
         rsp_we_q        <= 1'b0;
         rsp_timeout_q   <= 1'b0;
         rsp_valid_q     <= 1'b0;
         timeout_count_q <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               // s_cmd_ready is 1 here since reset_n is high in this branch
               if (s_cmd_valid) begin
                  adr_q      <= s_cmd_adr;
                  dat_q      <= s_cmd_dat;
                  sel_q      <= s_cmd_sel;
                  we_q       <= s_cmd_we;
                  rsp_we_q   <= s_cmd_we;
                  stb_q      <= 1'b1;
                  wait_cnt_q <= '0;
                  state_q    <= StBus;
               end
            end
            StBus: begin
               // Ack takes priority, so an ack on the last permitted cycle completes normally
               if (m_wb_ack_i) begin
                  rsp_dat_q     <= we_q ? '0 : m_wb_dat_i;
                  rsp_timeout_q <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  stb_q         <= 1'b0;
                  we_q          <= 1'b0;
                  state_q       <= StResp;
               end else if (wait_cnt_q == CntLast) begin
                  rsp_dat_q     <= '0;
                  rsp_timeout_q <= 1'b1;
                  rsp_valid_q   <= 1'b1;
                  stb_q         <= 1'b0;
                  we_q          <= 1'b0;
                  if (~&timeout_count_q) begin
                     timeout_count_q <= timeout_count_q + 1'b1;
                  end
                  state_q       <= StResp;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
            StResp: begin
               if (m_rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Only ready and busy are combinational.
   always_comb begin
      s_cmd_ready = (state_q == StIdle) && reset_n;
      busy        = (state_q != StIdle);
   end

   assign m_wb_adr_o    = adr_q;
   assign m_wb_dat_o    = dat_q;
   assign m_wb_sel_o    = sel_q;
   assign m_wb_we_o     = we_q;
   assign m_wb_stb_o    = stb_q;
   assign m_rsp_dat     = rsp_dat_q;
   assign m_rsp_we      = rsp_we_q;
   assign m_rsp_timeout = rsp_timeout_q;
   assign m_rsp_valid   = rsp_valid_q;
   assign timeout_count = timeout_count_q;

endmodule
